// File: rtl/controle_servo_multi_if.sv
// -----------------------------------------------------------------------------
// controle_servo_multi_if
// Command bus for the multi-channel servo PWM controller.
//
// Signals:
//   cmd_valid    single-cycle command strobe
//   cmd_canal    target channel ($clog2(N_CANAIS) bits, at least 1)
//   cmd_posicao  requested position (POS_BITS bits)
//
// Modports:
//   master  drives the command (host / testbench)
//   slave   receives the command (controle_servo_multi)
// -----------------------------------------------------------------------------
interface controle_servo_multi_if #(
   parameter int unsigned N_CANAIS = 3,
   parameter int unsigned POS_BITS = 8
);
   localparam int unsigned CANAL_BITS = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

   logic                  cmd_valid;
   logic [CANAL_BITS-1:0] cmd_canal;
   logic [POS_BITS-1:0]   cmd_posicao;

   modport master (output cmd_valid, cmd_canal, cmd_posicao);
   modport slave  (input  cmd_valid, cmd_canal, cmd_posicao);
endinterface

// File: rtl/controle_servo_multi.sv
// -----------------------------------------------------------------------------
// controle_servo_multi
// Multi-channel servo PWM controller. A single free-running period counter
// drives N_CANAIS servo outputs. Each channel's position command is mapped to
// a pulse width (LARGURA_MIN + posicao*DELTA, clipped to LARGURA_MAX) and held
// as the target (alvo). The applied width (atual) only changes on the period
// wrap, so no pulse is ever truncated or stretched.
//
// Optional feature (macro SERVO_RAMP_EN):
//   defined   -> at each wrap atual moves toward alvo by at most PASSO
//   undefined -> at each wrap atual takes alvo directly
//
// Ports:
//   clock              system clock
//   reset              asynchronous, active-high
//   cmd                command bus (controle_servo_multi_if.slave)
//   habilita           per-channel output enable, applied at the output register
//   pwm                registered servo outputs
//   ocupado            registered: channel's applied width differs from target
//   erro_canal         one-cycle pulse after a command to a nonexistent channel
//   db_reset           copy of reset
//   db_inicio_periodo  high while the period counter is 0
// -----------------------------------------------------------------------------
module controle_servo_multi #(
   parameter int unsigned N_CANAIS        = 3,
   parameter int unsigned CONF_PERIODO    = 1000000,
   parameter int unsigned LARGURA_MIN     = 50000,
   parameter int unsigned LARGURA_MAX     = 100000,
   parameter int unsigned LARGURA_REPOUSO = 75000,
   parameter int unsigned POS_BITS        = 8,
   parameter int unsigned DELTA           = 196,
   parameter int unsigned PASSO           = 500
) (
   input  logic                  clock,
   input  logic                  reset,
   controle_servo_multi_if.slave cmd,
   input  logic [N_CANAIS-1:0]   habilita,
   output logic [N_CANAIS-1:0]   pwm,
   output logic [N_CANAIS-1:0]   ocupado,
   output logic                  erro_canal,
   output logic                  db_reset,
   output logic                  db_inicio_periodo
);

   localparam int unsigned CANAL_BITS = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

`ifdef SERVO_RAMP_EN
   localparam logic [31:0] LIMITE_PASSO = 32'(PASSO);
`else
   // No step limit: any distance is covered in a single wrap.
   localparam logic [31:0] LIMITE_PASSO = 32'(PASSO) | 32'hFFFF_FFFF;
`endif

   // Next width for one channel at a wrap: step toward alvo, never overshoot.
   function automatic logic [31:0] aproxima(input logic [31:0] atual,
                                            input logic [31:0] alvo);
      logic [31:0] res;
      res = alvo;
      if (alvo > atual) begin
         if ((alvo - atual) > LIMITE_PASSO) res = atual + LIMITE_PASSO;
      end else begin
         if ((atual - alvo) > LIMITE_PASSO) res = atual - LIMITE_PASSO;
      end
      return res;
   endfunction

   logic [CANAL_BITS-1:0] canal;
   logic [POS_BITS-1:0]   posicao;

   logic [31:0]           contador_q, contador_d;
   logic                  wrap;
   logic                  cmd_ok;
   logic                  cmd_erro;
   logic [31:0]           largura_bruta;
   logic [31:0]           largura_cmd;

   logic [31:0]           alvo_q  [N_CANAIS];
   logic [31:0]           alvo_d  [N_CANAIS];
   logic [31:0]           atual_q [N_CANAIS];
   logic [31:0]           atual_d [N_CANAIS];

   logic [N_CANAIS-1:0]   pwm_q;
   logic [N_CANAIS-1:0]   ocupado_q;
   logic                  erro_q;

   assign canal   = cmd.cmd_canal;
   assign posicao = cmd.cmd_posicao;

   always_comb begin
      wrap          = (contador_q == 32'(CONF_PERIODO - 1));
      contador_d    = wrap ? '0 : contador_q + 32'd1;

      cmd_ok        = cmd.cmd_valid && (32'(canal) < N_CANAIS);
      cmd_erro      = cmd.cmd_valid && (32'(canal) >= N_CANAIS);

      largura_bruta = 32'(LARGURA_MIN) + 32'(posicao) * 32'(DELTA);
      largura_cmd   = (largura_bruta > 32'(LARGURA_MAX)) ? 32'(LARGURA_MAX)
                                                         : largura_bruta;

      for (int unsigned i = 0; i < N_CANAIS; i++) begin
         alvo_d[i]  = alvo_q[i];
         atual_d[i] = atual_q[i];
         if (cmd_ok && (32'(canal) == i)) alvo_d[i] = largura_cmd;
         // Using alvo_d lets a command on the wrap edge reach this update.
         if (wrap) atual_d[i] = aproxima(atual_q[i], alvo_d[i]);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         contador_q <= '0;
         pwm_q      <= '0;
         ocupado_q  <= '0;
         erro_q     <= 1'b0;
         for (int unsigned i = 0; i < N_CANAIS; i++) begin
            alvo_q[i]  <= 32'(LARGURA_REPOUSO);
            atual_q[i] <= 32'(LARGURA_REPOUSO);
         end
      end else begin
         contador_q <= contador_d;
         erro_q     <= cmd_erro;
         for (int unsigned i = 0; i < N_CANAIS; i++) begin
            alvo_q[i]    <= alvo_d[i];
            atual_q[i]   <= atual_d[i];
            // Compared against the current counter: the pulse lags it by one cycle.
            pwm_q[i]     <= habilita[i] & (contador_q < atual_q[i]);
            ocupado_q[i] <= (alvo_d[i] != atual_d[i]);
         end
      end
   end

   assign pwm               = pwm_q;
   assign ocupado           = ocupado_q;
   assign erro_canal        = erro_q;
   assign db_reset          = reset;
   assign db_inicio_periodo = (contador_q == '0);

endmodule

// File: tb/tb_controle_servo_multi.sv
// -----------------------------------------------------------------------------
// tb_controle_servo_multi
// Bench for controle_servo_multi with small parameters (period 100 cycles).
// A reference model tracks target/applied widths per channel and pushes the
// expected pulse widths of each period into a queue; a monitor measures the
// pulses and compares them on every period boundary. Also honours
// SERVO_RAMP_EN when defined.
// -----------------------------------------------------------------------------
module tb_controle_servo_multi;

   localparam int NC   = 3;
   localparam int PER  = 100;
   localparam int LMIN = 10;
   localparam int LMAX = 50;
   localparam int LREP = 30;
   localparam int PB   = 5;
   localparam int DLT  = 2;
   localparam int STEP = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [NC-1:0] habilita;
   logic [NC-1:0] pwm;
   logic [NC-1:0] ocupado;
   logic          erro_canal;
   logic          db_reset;
   logic          db_inicio_periodo;

   controle_servo_multi_if #(.N_CANAIS(NC), .POS_BITS(PB)) cmd_if ();

   controle_servo_multi #(
      .N_CANAIS        (NC),
      .CONF_PERIODO    (PER),
      .LARGURA_MIN     (LMIN),
      .LARGURA_MAX     (LMAX),
      .LARGURA_REPOUSO (LREP),
      .POS_BITS        (PB),
      .DELTA           (DLT),
      .PASSO           (STEP)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .cmd               (cmd_if),
      .habilita          (habilita),
      .pwm               (pwm),
      .ocupado           (ocupado),
      .erro_canal        (erro_canal),
      .db_reset          (db_reset),
      .db_inicio_periodo (db_inicio_periodo)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic verifica(input string tag, input logic [31:0] obtido,
                           input logic [31:0] esperado);
      n_checks++;
      if (obtido === esperado) n_pass++;
      else $display("FAIL %s: obtido=%0d esperado=%0d", tag, obtido, esperado);
   endtask

   // ---------------- reference model ----------------
   int              m_cnt;
   int              m_alvo  [NC];
   int              m_atual [NC];
   logic [NC-1:0]   m_ocup;
   logic            m_err;
   logic            m_skip;
   logic [NC-1:0][31:0] exp_q[$];

   function automatic int largura_de(input int pos);
      int w;
      w = LMIN + pos * DLT;
      if (w > LMAX) w = LMAX;
      return w;
   endfunction

   function automatic int proxima(input int at, input int al);
`ifdef SERVO_RAMP_EN
      if (al > at) return (al - at > STEP) ? at + STEP : al;
      else         return (at - al > STEP) ? at - STEP : al;
`else
      return al + 0 * at;
`endif
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_cnt  = 0;
         m_ocup = '0;
         m_err  = 1'b0;
         m_skip = 1'b1;
         for (int i = 0; i < NC; i++) begin
            m_alvo[i]  = LREP;
            m_atual[i] = LREP;
         end
         exp_q.delete();
      end else begin
         logic [NC-1:0][31:0] e;
         m_err = cmd_if.cmd_valid && (int'(cmd_if.cmd_canal) >= NC);
         if (cmd_if.cmd_valid && (int'(cmd_if.cmd_canal) < NC))
            m_alvo[int'(cmd_if.cmd_canal)] = largura_de(int'(cmd_if.cmd_posicao));
         if (m_cnt == 0) begin
            // Period starting now: first one after reset is not measured.
            for (int i = 0; i < NC; i++) e[i] = habilita[i] ? 32'(m_atual[i]) : 32'd0;
            if (!m_skip) exp_q.push_back(e);
            m_skip = 1'b0;
         end
         if (m_cnt == PER - 1) begin
            m_cnt = 0;
            for (int i = 0; i < NC; i++) m_atual[i] = proxima(m_atual[i], m_alvo[i]);
         end else begin
            m_cnt = m_cnt + 1;
         end
         for (int i = 0; i < NC; i++) m_ocup[i] = (m_alvo[i] != m_atual[i]);
      end
   end

   // ---------------- monitor ----------------
   int cnt_hi [NC];

   always @(negedge clock) begin
      if (reset) begin
         for (int i = 0; i < NC; i++) cnt_hi[i] = 0;
      end else begin
         logic [NC-1:0][31:0] e;
         verifica("inicio_periodo", 32'(db_inicio_periodo), 32'(m_cnt == 0));
         verifica("erro_canal", 32'(erro_canal), 32'(m_err));
         verifica("ocupado", 32'(ocupado), 32'(m_ocup));
         for (int i = 0; i < NC; i++) cnt_hi[i] = cnt_hi[i] + int'(pwm[i]);
         if (m_cnt == 0) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               for (int i = 0; i < NC; i++)
                  verifica($sformatf("largura_ch%0d", i), 32'(cnt_hi[i]), e[i]);
            end
            for (int i = 0; i < NC; i++) cnt_hi[i] = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic espera_cnt(input int n);
      int k;
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (m_cnt != n && k < 3 * PER);
      if (m_cnt != n) verifica("espera_cnt", 32'(m_cnt), 32'(n));
   endtask

   task automatic periodos(input int p);
      repeat (p) espera_cnt(0);
   endtask

   task automatic comando(input int canal, input int pos);
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_canal   = 2'(canal);
      cmd_if.cmd_posicao = 5'(pos);
      @(negedge clock);
      cmd_if.cmd_valid   = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      habilita           = 3'b111;
      cmd_if.cmd_valid   = 1'b0;
      cmd_if.cmd_canal   = '0;
      cmd_if.cmd_posicao = '0;
      repeat (3) @(negedge clock);
      verifica("rst_pwm", 32'(pwm), 32'd0);
      verifica("rst_ocupado", 32'(ocupado), 32'd0);
      verifica("rst_erro", 32'(erro_canal), 32'd0);
      verifica("rst_db_reset", 32'(db_reset), 32'd1);
      verifica("rst_inicio", 32'(db_inicio_periodo), 32'd1);
      reset = 1'b0;
      verifica("db_reset_solto", 32'(db_reset), 32'd0);
      periodos(3);

      // Mid-period command: channel 1 -> 40
      espera_cnt(50);
      comando(1, 15);
      periodos(5);

      // Clipped command on the wrap edge: channel 0 -> 50
      espera_cnt(PER - 1);
      comando(0, 31);
      periodos(7);

      // Invalid channel
      espera_cnt(40);
      comando(3, 7);
      periodos(2);

      // Enable gating of channel 2 for two periods
      espera_cnt(0);
      habilita = 3'b011;
      periodos(2);
      habilita = 3'b111;
      periodos(2);

      // Asynchronous reset in the middle of the pulse
      espera_cnt(20);
      verifica("pre_rst_pwm", 32'(pwm), 32'h7);
      reset = 1'b1;
      #1;
      verifica("rst_async_pwm", 32'(pwm), 32'd0);
      verifica("rst_async_ocupado", 32'(ocupado), 32'd0);
      verifica("rst_async_inicio", 32'(db_inicio_periodo), 32'd1);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      periodos(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: obtido=timeout esperado=fim");
      $fatal(1, "watchdog");
   end

endmodule
